multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle MIPS32 core. It sequences the shared ALU, register file, memory port and PC through fetch, decode, execute, memory and writeback steps, one state per cycle, and stalls on a memory-ready handshake. It produces the 2-bit `aluop` that the ALU control decoder combines with `funct` to select the ALU operation. It sits between the instruction register opcode field and every datapath mux and write enable.

## Interface
- No parameters. Encodings are fixed in the shared package.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]; sampled in DECODE and MEMADR.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `mem_rd`, `mem_wr` output 1: memory read and write strobes.
- `iord` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write` output 1: load IR; unconditional PC write.
- `branch` output 1: PC write qualified by ALU zero.
- `pc_src` output 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 register B, 01 constant 4, 10 extended immediate, 11 shifted immediate.
- `zero_ext` output 1: immediate extender zero-extends instead of sign-extending.
- `aluop` output 2: 00 add, 01 sub, 10 use funct, 11 or.
- `reg_dst`, `mem_to_reg`, `reg_write` output 1: register-file write controls.
- `illegal` output 1: sticky unsupported-opcode flag.
- `state` output 4: current state, for debug.

## Operation
- States and transitions:
  - FETCH: waits in place while `mem_ready`=0; goes to DECODE on `mem_ready`=1.
  - DECODE: dispatches on `opcode`. 0 → RTEX, 35/43 → MEMADR, 4 → BEQEX, 8 → ADDIEX, 13 → ORIEX, 2 → JEX, anything else → ILLEGAL.
  - MEMADR: goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: waits for `mem_ready`, then goes to MEMWB.
  - MEMWR: waits for `mem_ready`, then goes to FETCH.
  - RTEX → RTWB. ADDIEX and ORIEX → IMMWB. MEMWB, RTWB, IMMWB, BEQEX and JEX → FETCH.
  - ILLEGAL: self-loops until reset.
- Moore outputs per state; every output not listed is 0:
  - FETCH: `mem_rd`, `alu_src_b`=01, `aluop`=00. `ir_write` and `pc_write` are asserted only in the cycle `mem_ready`=1 (Mealy).
  - DECODE: `alu_src_b`=11, `aluop`=00, to precompute the branch target.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00.
  - MEMRD: `mem_rd`, `iord`. MEMWR: `mem_wr`, `iord`.
  - MEMWB: `reg_write`, `mem_to_reg`.
  - RTEX: `alu_src_a`=1, `aluop`=10. RTWB: `reg_write`, `reg_dst`.
  - BEQEX: `alu_src_a`=1, `aluop`=01, `branch`, `pc_src`=01.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00.
  - ORIEX: the same as ADDIEX plus `zero_ext`=1 and `aluop`=11.
  - IMMWB: `reg_write`.
  - JEX: `pc_write`, `pc_src`=10.
  - ILLEGAL: `illegal`=1 only.
- Strobe rule: `mem_rd` and `mem_wr` stay asserted, with the address held, for every wait cycle until `mem_ready`.

## Timing
- Reset: state = FETCH and `illegal`=0. Every strobe and write enable is forced to 0 while `reset_n`=0. FETCH takes effect on the first edge after release.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, addi/ori 4, j 3. Each wait cycle adds 1 cycle to FETCH, MEMRD or MEMWR.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- A reset asserted mid-instruction aborts it immediately. No partial write completes after the reset edge.

## Configuration
- `MC_JUMP_EN` defined: opcode 2 is decoded to JEX.
- `MC_JUMP_EN` undefined: JEX is not built, opcode 2 goes to ILLEGAL, and `pc_src` never takes the value 10.

## Structure
- Package `mc_pkg` holds:
  - the state enum, 4-bit binary;
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J;
  - the ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT and ALUOP_OR constants.
- One sub-module, `mc_out_decode`: combinational state-to-control decode.
- The top level holds the state register and next-state logic.

## Test plan
- Zero-wait memory, opcode 0: states FETCH, DECODE, RTEX, RTWB, FETCH in 4 cycles. `aluop`=10 in RTEX; `reg_write`=1 and `reg_dst`=1 in RTWB.
- lw (35) with `mem_ready` low for 2 cycles in MEMRD: 7 cycles total, `mem_rd`=1 and `iord`=1 held for 3 cycles, then MEMWB with `mem_to_reg`=1.
- beq (4): 3 cycles. BEQEX drives `aluop`=01, `branch`=1, `pc_src`=01, `pc_write`=0.
- ori (13): ORIEX drives `aluop`=11 and `zero_ext`=1, then IMMWB drives `reg_write`=1.
- Opcode 63: ILLEGAL reached and `illegal`=1 held for 20 cycles. Opcode 2 behaves the same without `MC_JUMP_EN`; with it, JEX drives `pc_src`=10.
- Assert `reset_n` low in MEMWR with `mem_ready` low: `mem_wr` drops to 0 asynchronously, and FETCH is reached after release.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and ALU-op encodings for multicycle_control (jump support via MC_JUMP_EN)
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTEX    = 4'd6,
      RTWB    = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ORIEX   = 4'd10,
      IMMWB   = 4'd11,
      JEX     = 4'd12,
      ILLEGAL = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   typedef struct packed {
      logic       mem_rd;
      logic       mem_wr;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [1:0] aluop;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath control outputs of the control FSM
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_rd;
   logic       mem_wr;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic       branch;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       zero_ext;
   logic [1:0] aluop;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, mem_ready,
      output mem_rd, mem_wr, iord, ir_write, pc_write, branch, pc_src, alu_src_a,
             alu_src_b, zero_ext, aluop, reg_dst, mem_to_reg, reg_write, illegal, state
   );

   modport slave (
      output opcode, mem_ready,
      input  mem_rd, mem_wr, iord, ir_write, pc_write, branch, pc_src, alu_src_a,
             alu_src_b, zero_ext, aluop, reg_dst, mem_to_reg, reg_write, illegal, state
   );
endinterface

// File: rtl/mc_out_decode.sv
// mc_out_decode: state-to-control decode; JEX decode present only with MC_JUMP_EN
module mc_out_decode import mc_pkg::*; (
   input  state_t state_i,
   input  logic   mem_ready_i,
   input  logic   en_i,
   output ctrl_t  ctrl_o
);
   ctrl_t c;

   // Moore controls per state, IR/PC load in FETCH qualified by mem_ready; all forced low while en_i is low
   always_comb begin
      c = '0;
      case (state_i)
         FETCH:   begin c.mem_rd = 1'b1; c.alu_src_b = 2'b01; c.aluop = ALUOP_ADD; c.ir_write = mem_ready_i; c.pc_write = mem_ready_i; end
         DECODE:  begin c.alu_src_b = 2'b11; c.aluop = ALUOP_ADD; end
         MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluop = ALUOP_ADD; end
         MEMRD:   begin c.mem_rd = 1'b1; c.iord = 1'b1; end
         MEMWR:   begin c.mem_wr = 1'b1; c.iord = 1'b1; end
         MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         RTEX:    begin c.alu_src_a = 1'b1; c.aluop = ALUOP_FUNCT; end
         RTWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         BEQEX:   begin c.alu_src_a = 1'b1; c.aluop = ALUOP_SUB; c.branch = 1'b1; c.pc_src = 2'b01; end
         ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluop = ALUOP_ADD; end
         ORIEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluop = ALUOP_OR; c.zero_ext = 1'b1; end
         IMMWB:   c.reg_write = 1'b1;
`ifdef MC_JUMP_EN
         JEX:     begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
`endif
         ILLEGAL: c.illegal = 1'b1;
         default: c = '0;
      endcase
      ctrl_o = en_i ? c : '0;
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS32 main control FSM; define MC_JUMP_EN to decode j (opcode 2)
module multicycle_control import mc_pkg::*; (
   input  logic                clk,
   input  logic                reset_n,
   multicycle_control_if.master bus
);
   state_t state_q, state_d;
   ctrl_t  ctrl;

   function automatic state_t dispatch(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return RTEX;
         OP_LW, OP_SW: return MEMADR;
         OP_BEQ:       return BEQEX;
         OP_ADDI:      return ADDIEX;
         OP_ORI:       return ORIEX;
`ifdef MC_JUMP_EN
         OP_J:         return JEX;
`endif
         default:      return ILLEGAL;
      endcase
   endfunction

   // Next state: memory states stall on mem_ready, ILLEGAL holds until reset
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:         state_d = bus.mem_ready ? DECODE : FETCH;
         DECODE:        state_d = dispatch(bus.opcode);
         MEMADR:        state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:         state_d = bus.mem_ready ? MEMWB : MEMRD;
         MEMWR:         state_d = bus.mem_ready ? FETCH : MEMWR;
         RTEX:          state_d = RTWB;
         ADDIEX, ORIEX: state_d = IMMWB;
         ILLEGAL:       state_d = ILLEGAL;
         default:       state_d = FETCH;
      endcase
   end

   // State register, asynchronously returned to FETCH by reset
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;

   mc_out_decode u_dec (
      .state_i     (state_q),
      .mem_ready_i (bus.mem_ready),
      .en_i        (reset_n),
      .ctrl_o      (ctrl)
   );

   assign bus.mem_rd     = ctrl.mem_rd;
   assign bus.mem_wr     = ctrl.mem_wr;
   assign bus.iord       = ctrl.iord;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.pc_write   = ctrl.pc_write;
   assign bus.branch     = ctrl.branch;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.zero_ext   = ctrl.zero_ext;
   assign bus.aluop      = ctrl.aluop;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.illegal    = ctrl.illegal;
   assign bus.state      = state_q;
endmodule
